// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, branch flushes, and
// data-memory wait freezes with timeout. Optional stall counter: STALL_CTRL_PERF_EN.
module stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ifid_inst_i,
  input  logic [4:0]  idex_rt_i,
  input  logic        idex_memread_i,
  input  logic        branch_taken_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ack_i,
  output logic        pc_we_o,
  output logic        ifid_we_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        freeze_o,
  output logic        err_o,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } state_t;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] tmo_cnt, tmo_nxt;
  logic [4:0] rs, rt;
  logic       lu, ms;
  logic       pc_we, ifid_we, ifid_flush, idex_bubble, freeze;
  logic       unused_inst;

  assign rs          = ifid_inst_i[25:21];
  assign rt          = ifid_inst_i[20:16];
  assign unused_inst = ^{ifid_inst_i[31:26], ifid_inst_i[15:0]};

  assign lu = idex_memread_i & (idex_rt_i != 5'd0) & ((idex_rt_i == rs) | (idex_rt_i == rt));
  assign ms = dmem_req_i & ~dmem_ack_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= RUN;
      tmo_cnt <= 8'd0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tmo_nxt     = tmo_cnt;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    freeze      = 1'b0;
    case (state)
      RUN: begin
        if (ms) begin
          freeze    = 1'b1;
          state_nxt = MEM_WAIT;
          tmo_nxt   = 8'd1;
        end else if (lu) begin
          // a taken branch is held back until the hazard clears
          idex_bubble = 1'b1;
        end else begin
          pc_we      = 1'b1;
          ifid_we    = 1'b1;
          ifid_flush = branch_taken_i;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ack_i) begin
          freeze = 1'b1;
          if (tmo_cnt >= TMO) state_nxt = ERROR;
          else                tmo_nxt   = tmo_cnt + 8'd1;
        end else begin
          // ack cycle resolves exactly like a stall-free RUN cycle
          state_nxt = RUN;
          tmo_nxt   = 8'd0;
          if (lu) begin
            idex_bubble = 1'b1;
          end else begin
            pc_we      = 1'b1;
            ifid_we    = 1'b1;
            ifid_flush = branch_taken_i;
          end
        end
      end
      ERROR: begin
        freeze = 1'b1;
      end
      default: begin
        state_nxt = RUN;
        tmo_nxt   = 8'd0;
      end
    endcase
  end

  // reset forces every control output low without waiting for a clock
  assign pc_we_o       = rst_i & pc_we;
  assign ifid_we_o     = rst_i & ifid_we;
  assign ifid_flush_o  = rst_i & ifid_flush;
  assign idex_bubble_o = rst_i & idex_bubble;
  assign freeze_o      = rst_i & freeze;
  assign err_o         = (state == ERROR);
  assign state_o       = state;

`ifdef STALL_CTRL_PERF_EN
  logic [15:0] perf_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      perf_cnt <= 16'd0;
    else if ((state != ERROR) && !pc_we && (perf_cnt != 16'hFFFF))
      perf_cnt <= perf_cnt + 16'd1;
  end

  assign stall_cnt_o = perf_cnt;
`else
  assign stall_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl (MEM_TIMEOUT=4); checks outputs #1 after each negedge.
module tb_stall_ctrl;

`ifdef STALL_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk, rst;
  logic [31:0] inst;
  logic [4:0]  idex_rt;
  logic        memread, branch, req, ack;
  logic        pc_we, ifid_we, flush, bubble, freeze, err;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  int          total = 0;
  int          bad   = 0;

  stall_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst), .ifid_inst_i(inst), .idex_rt_i(idex_rt),
    .idex_memread_i(memread), .branch_taken_i(branch), .dmem_req_i(req),
    .dmem_ack_i(ack), .pc_we_o(pc_we), .ifid_we_o(ifid_we), .ifid_flush_o(flush),
    .idex_bubble_o(bubble), .freeze_o(freeze), .err_o(err), .state_o(state),
    .stall_cnt_o(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic setin(input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                       input logic [4:0] irt, input logic br, input logic rq, input logic ak);
    memread = mr; idex_rt = xrt; inst = {6'h23, rs, irt, 16'h1234};
    branch = br; req = rq; ack = ak;
  endtask

  // ctl = {pc_we, ifid_we, flush, bubble, freeze, err}
  task automatic chk(input string tag, input logic [5:0] ctl, input logic [1:0] st,
                     input int unsigned n);
    logic [23:0] obs, exp;
    obs = {pc_we, ifid_we, flush, bubble, freeze, err, state, stall_cnt};
    exp = {ctl, st, (PERF ? 16'(n) : 16'h0000)};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [5:0] ctl, input logic [1:0] st,
                      input int unsigned n);
    #1;
    chk(tag, ctl, st, n);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    setin(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    #1 chk("reset", 6'b000000, 2'b00, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    setin(1'b0, 5'd0, 5'd1, 5'd3, 1'b0, 1'b0, 1'b0);
    step("run_idle", 6'b110000, 2'b00, 0);
    setin(1'b1, 5'd2, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0);
    step("lu_rs", 6'b000100, 2'b00, 0);
    setin(1'b0, 5'd2, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0);
    step("lu_after", 6'b110000, 2'b00, 1);
    setin(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("lu_r0", 6'b110000, 2'b00, 1);
    setin(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0);
    step("lu_rt_br", 6'b000100, 2'b00, 1);
    setin(1'b0, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0);
    step("br_flush", 6'b111000, 2'b00, 2);
    setin(1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b1, 1'b1);
    step("mem_hit", 6'b110000, 2'b00, 2);

    // miss acked on the third cycle, branch held throughout
    setin(1'b0, 5'd0, 5'd1, 5'd1, 1'b1, 1'b1, 1'b0);
    step("ms_run", 6'b000010, 2'b00, 2);
    step("ms_w1", 6'b000010, 2'b01, 3);
    step("ms_w2", 6'b000010, 2'b01, 4);
    setin(1'b0, 5'd0, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1);
    step("ms_ack", 6'b111000, 2'b01, 5);
    setin(1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b0, 1'b0);
    step("ms_back", 6'b110000, 2'b00, 5);

    // ack arrives the cycle the counter hits MEM_TIMEOUT
    setin(1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b1, 1'b0);
    step("edge_run", 6'b000010, 2'b00, 5);
    step("edge_w1", 6'b000010, 2'b01, 6);
    step("edge_w2", 6'b000010, 2'b01, 7);
    step("edge_w3", 6'b000010, 2'b01, 8);
    setin(1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b1, 1'b1);
    step("edge_ack", 6'b110000, 2'b01, 9);
    setin(1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b0, 1'b0);
    step("edge_back", 6'b110000, 2'b00, 9);

    // timeout into ERROR, then ack and hazards are ignored
    setin(1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b1, 1'b0);
    step("to_run", 6'b000010, 2'b00, 9);
    step("to_w1", 6'b000010, 2'b01, 10);
    step("to_w2", 6'b000010, 2'b01, 11);
    step("to_w3", 6'b000010, 2'b01, 12);
    step("to_w4", 6'b000010, 2'b01, 13);
    step("err", 6'b000011, 2'b10, 14);
    setin(1'b1, 5'd1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1);
    step("err_ack", 6'b000011, 2'b10, 14);
    step("err_hold", 6'b000011, 2'b10, 14);
    #3 rst = 1'b0;
    #1 chk("err_rst", 6'b000000, 2'b00, 0);
    @(negedge clk);
    rst = 1'b1;
    setin(1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b0, 1'b0);
    step("err_rel", 6'b110000, 2'b00, 0);

    // reset pulsed mid-cycle while in MEM_WAIT
    setin(1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b1, 1'b0);
    step("mw_run", 6'b000010, 2'b00, 0);
    #1 chk("mw_w1", 6'b000010, 2'b01, 1);
    #2 rst = 1'b0;
    #1 chk("mw_rst", 6'b000000, 2'b00, 0);
    @(negedge clk);
    rst = 1'b1;
    setin(1'b0, 5'd0, 5'd1, 5'd1, 1'b0, 1'b0, 1'b0);
    step("mw_rel", 6'b110000, 2'b00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
